wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
Two-master round-robin Wishbone arbiter with a bus-watchdog timeout. It shares one slave-side Wishbone path between the CPU data master (m0) and a secondary master (m1, a DMA or VGA fetch engine). It grants one owner per transfer and muxes that owner's cycle onto the shared bus. Any slave that fails to acknowledge is terminated with an error so the requesting master never hangs.

Parameters:
TIMEOUT, 255, OWN cycles allowed before forced error termination; 0 disables the watchdog
CNT_W, 8, width of the watchdog counter; must satisfy TIMEOUT < 2^CNT_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
m0_adr_i  in  32  master 0 address
m0_dat_i  in  32  master 0 write data
m0_sel_i  in  4  master 0 byte selects
m0_we_i  in  1  master 0 write enable
m0_stb_i  in  1  master 0 request; held until ack or err
m0_dat_o  out  32  read data to master 0
m0_ack_o  out  1  transfer done, master 0
m0_err_o  out  1  timeout error, master 0
m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_stb_i, m1_dat_o, m1_ack_o, m1_err_o: identical to m0_*, for master 1
s_adr_o  out  32  shared bus address
s_dat_o  out  32  shared bus write data
s_sel_o  out  4  shared bus byte selects
s_we_o  out  1  shared bus write enable
s_stb_o  out  1  shared bus strobe
s_dat_i  in  32  slave read data
s_ack_i  in  1  slave acknowledge
gnt_o  out  2  one-hot current owner; 00 when idle
err_cnt_o  out  8  saturating count of timeouts

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, last (last-served master), cnt[CNT_W-1:0], err_cnt[7:0].
- Reset values: state=IDLE, last=1 (so m0 wins the first tie), cnt=0, err_cnt=0.
- Reset is synchronous. If rst is asserted mid-transfer, s_stb_o and gnt_o drop in the cycle after the edge that samples rst. No ack or err is issued for the aborted transfer.
- IDLE outputs: all s_* outputs 0, gnt_o=00, all m*_ack_o, m*_err_o and m*_dat_o = 0.
- IDLE transitions:
  - only m0_stb_i -> OWN0; only m1_stb_i -> OWN1.
  - both asserted -> grant the master != last.
  - cnt cleared on every grant.
- OWNx outputs (combinational mux):
  - s_adr_o/s_dat_o/s_sel_o/s_we_o = mx_*.
  - s_stb_o = mx_stb_i & ~timeout_hit.
  - gnt_o bit x = 1.
  - mx_ack_o = s_ack_i; mx_dat_o = s_dat_i.
  - non-owner ack/err/dat = 0.
- OWNx transitions:
  - s_ack_i -> IDLE, last=x.
  - mx_stb_i dropped without ack (abort) -> IDLE, last=x, no err.
  - otherwise cnt increments.
- Watchdog (TIMEOUT != 0):
  - timeout_hit = (cnt == TIMEOUT-1) & ~s_ack_i, evaluated in OWNx.
  - When hit: mx_err_o=1 for exactly that cycle, s_stb_o=0 that cycle, then -> IDLE, last=x, err_cnt += 1 (saturates at 255).
  - If ack and timeout coincide, the ack wins and no err is issued.
- TIMEOUT=0: cnt is held at 0 and never hits; a non-acking slave hangs the owner. This is a documented hazard.
- Latency:
  - stb sampled in IDLE at edge k -> s_stb_o high from cycle k+1.
  - A zero-wait slave acks in cycle k+1.
  - Mandatory one IDLE turnaround cycle after every ack/err/abort, so the minimum transfer period is 2 cycles.
  - Under continuous requests from both masters, grants strictly alternate.
- Starvation bound: a requesting master waits at most one full transfer of the other master plus one turnaround cycle.

Test Plan:
1. Single m0 read: m0_stb_i=1, adr=0x0000_0040, zero-wait slave returns 0xDEADBEEF -> gnt_o=01 in cycle 1, s_adr_o=0x40, m0_ack_o=1 with m0_dat_o=0xDEADBEEF in cycle 1, IDLE in cycle 2.
2. Simultaneous requests out of reset, both held continuously for 4 transfers -> grant order m0,m1,m0,m1; s_stb_o low on every turnaround cycle; m1_ack_o never asserted while gnt_o=01.
3. Timeout, TIMEOUT=4, m1 write to a non-acking slave -> s_stb_o high cycles 1–3, m1_err_o=1 and s_stb_o=0 in cycle 4, err_cnt_o=1, IDLE in cycle 5.
4. Ack coinciding with the timeout cycle (slave acks in cycle 4, TIMEOUT=4) -> m1_ack_o=1, m1_err_o=0, err_cnt_o unchanged.
5. Abort: m0 drops stb in cycle 2 of a wait-stated transfer -> IDLE next cycle, no ack/err, pending m1 granted afterwards.
6. rst pulsed during OWN0 with slave stalled -> s_stb_o=0, gnt_o=00, err_cnt_o=0 after the edge; the next simultaneous request grants m0 first.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with a bus watchdog.
// It shares one slave path between m0 and m1, and a non-acking slave is ended with an error.
module wb_rr_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam bit WDOG_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic             last_r, last_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       err_cnt_r, err_cnt_s;

  logic             own1_s;
  logic             own_stb_s;
  logic             hit_s;

  // Owner select and watchdog hit; own1_s is only meaningful while a master owns the bus
  always_comb begin
    own1_s    = (state_r == OWN1);
    own_stb_s = own1_s ? m1_stb_i : m0_stb_i;
    hit_s     = 1'b0;
    if ((state_r == OWN0) || (state_r == OWN1)) begin
      hit_s = WDOG_EN && (cnt_r == CNT_LAST) && !s_ack_i;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Next-state logic and the combinational bus mux
  always_comb begin
    state_s   = state_r;
    last_s    = last_r;
    cnt_s     = cnt_r;
    err_cnt_s = err_cnt_r;
    s_adr_o   = 32'h0;
    s_dat_o   = 32'h0;
    s_sel_o   = 4'h0;
    s_we_o    = 1'b0;
    s_stb_o   = 1'b0;
    gnt_o     = 2'b00;
    m0_dat_o  = 32'h0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_dat_o  = 32'h0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (m0_stb_i && m1_stb_i) begin
          state_s = last_r ? OWN0 : OWN1;
        end else if (m0_stb_i) begin
          state_s = OWN0;
        end else if (m1_stb_i) begin
          state_s = OWN1;
        end else begin
          state_s = IDLE;
        end
      end
      OWN0, OWN1: begin
        s_adr_o = own1_s ? m1_adr_i : m0_adr_i;
        s_dat_o = own1_s ? m1_dat_i : m0_dat_i;
        s_sel_o = own1_s ? m1_sel_i : m0_sel_i;
        s_we_o  = own1_s ? m1_we_i  : m0_we_i;
        s_stb_o = own_stb_s && !hit_s;
        gnt_o   = own1_s ? 2'b10 : 2'b01;
        if (own1_s) begin
          m1_ack_o = s_ack_i;
          m1_dat_o = s_dat_i;
          m1_err_o = hit_s && own_stb_s;
        end else begin
          m0_ack_o = s_ack_i;
          m0_dat_o = s_dat_i;
          m0_err_o = hit_s && own_stb_s;
        end
        // Ack beats abort, abort beats timeout: an aborted cycle never reports an error
        if (s_ack_i || !own_stb_s) begin
          state_s = IDLE;
          last_s  = own1_s;
        end else if (hit_s) begin
          state_s   = IDLE;
          last_s    = own1_s;
          err_cnt_s = (err_cnt_r == 8'hFF) ? err_cnt_r : (err_cnt_r + 8'd1);
        end else if (WDOG_EN) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = '0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; last=1 lets m0 win the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      last_r    <= 1'b1;
      cnt_r     <= '0;
      err_cnt_r <= 8'h00;
    end else begin
      state_r   <= state_s;
      last_r    <= last_s;
      cnt_r     <= cnt_s;
      err_cnt_r <= err_cnt_s;
    end
  end

  assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus random traffic
// compared each cycle against a transaction-age reference model.
module tb_wb_rr_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_stb [2];
  logic [31:0] s_dat;
  logic        s_ack;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_stb_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;
  logic [7:0]  err_cnt_o;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_stb_i(m_stb[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_stb_i(m_stb[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt_o(gnt_o), .err_cnt_o(err_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner (-1 idle), cycles spent owning the bus, last served, error tally
  int owner, age, last, errs;
  bit done [2];
  logic [1:0] obs_gnt;
  logic [1:0] gnt_seq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; age = 0; last = 1; errs = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge
  task automatic step();
    logic [31:0] e_adr, e_wdat;
    logic [3:0]  e_sel;
    logic        e_we, e_stb;
    logic [1:0]  e_gnt;
    logic [31:0] e_rdat [2];
    logic        e_ack [2];
    logic        e_err [2];
    bit          hit, stbx;
    int          n_owner, n_age, n_last, n_errs;
    e_adr = 32'h0; e_wdat = 32'h0; e_sel = 4'h0; e_we = 1'b0; e_stb = 1'b0; e_gnt = 2'b00;
    for (int i = 0; i < 2; i++) begin
      e_rdat[i] = 32'h0; e_ack[i] = 1'b0; e_err[i] = 1'b0;
    end
    @(negedge clk);
    hit = 1'b0;
    stbx = 1'b0;
    if (owner >= 0) begin
      stbx = m_stb[owner];
      hit = (age == TO) && !s_ack;
      e_adr = m_adr[owner]; e_wdat = m_dat[owner]; e_sel = m_sel[owner]; e_we = m_we[owner];
      e_stb = stbx && !hit;
      e_gnt = (owner == 0) ? 2'b01 : 2'b10;
      e_ack[owner] = s_ack;
      e_rdat[owner] = s_dat;
      e_err[owner] = hit && stbx;
    end
    chk("s_adr", s_adr_o, e_adr);
    chk("s_dat", s_dat_o, e_wdat);
    chk("s_sel", {28'h0, s_sel_o}, {28'h0, e_sel});
    chk("s_we", {31'h0, s_we_o}, {31'h0, e_we});
    chk("s_stb", {31'h0, s_stb_o}, {31'h0, e_stb});
    chk("gnt", {30'h0, gnt_o}, {30'h0, e_gnt});
    chk("err_cnt", {24'h0, err_cnt_o}, 32'(errs));
    chk("m0_ack", {31'h0, m0_ack_o}, {31'h0, e_ack[0]});
    chk("m0_err", {31'h0, m0_err_o}, {31'h0, e_err[0]});
    chk("m0_dat", m0_dat_o, e_rdat[0]);
    chk("m1_ack", {31'h0, m1_ack_o}, {31'h0, e_ack[1]});
    chk("m1_err", {31'h0, m1_err_o}, {31'h0, e_err[1]});
    chk("m1_dat", m1_dat_o, e_rdat[1]);
    obs_gnt = gnt_o;
    if (gnt_o != 2'b00) gnt_seq.push_back(gnt_o);
    for (int i = 0; i < 2; i++) done[i] = e_ack[i] || e_err[i];

    n_owner = owner; n_age = age; n_last = last; n_errs = errs;
    if (rst) begin
      n_owner = -1; n_age = 0; n_last = 1; n_errs = 0;
    end else if (owner < 0) begin
      if (m_stb[0] && m_stb[1]) n_owner = 1 - last;
      else if (m_stb[0]) n_owner = 0;
      else if (m_stb[1]) n_owner = 1;
      n_age = 1;
    end else if (s_ack || !stbx || hit) begin
      if (hit && stbx && errs < 255) n_errs = errs + 1;
      n_last = owner;
      n_owner = -1;
    end else begin
      n_age = age + 1;
    end
    @(posedge clk);
    #1;
    owner = n_owner; age = n_age; last = n_last; errs = n_errs;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = 32'h0; m_dat[i] = 32'h0; m_sel[i] = 4'h0; m_we[i] = 1'b0; m_stb[i] = 1'b0;
    end
    s_ack = 1'b0;
    s_dat = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic new_req(input int i);
    m_stb[i] = 1'b1;
    m_adr[i] = $urandom;
    m_dat[i] = $urandom;
    m_sel[i] = 4'($urandom);
    m_we[i]  = 1'($urandom);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // 1: single zero-wait m0 read
    m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0040;
    s_ack = 1'b1; s_dat = 32'hDEADBEEF;
    step();
    step();
    chk("t1_gnt", {30'h0, obs_gnt}, 32'h1);
    m_stb[0] = 1'b0;
    step();

    // 2: both masters request continuously from reset; grants must alternate from m0
    do_reset();
    gnt_seq.delete();
    m_stb[0] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_0080;
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    for (int k = 0; k < 8; k++) step();
    chk("t2_count", 32'(gnt_seq.size()), 32'd4);
    for (int k = 0; k < 4 && k < gnt_seq.size(); k++)
      chk("t2_order", {30'h0, gnt_seq[k]}, (k % 2 == 0) ? 32'h1 : 32'h2);

    // 3: m1 write to a slave that never acks
    do_reset();
    m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'h0000_1000; m_dat[1] = 32'hCAFE_F00D;
    s_ack = 1'b0;
    for (int k = 0; k < 5; k++) step();
    m_stb[1] = 1'b0;
    step();
    chk("t3_err_cnt", {24'h0, err_cnt_o}, 32'h1);

    // 4: slave acks exactly on the would-be timeout cycle
    m_stb[1] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    s_ack = 1'b1;
    step();
    m_stb[1] = 1'b0; s_ack = 1'b0;
    step();
    chk("t4_err_cnt", {24'h0, err_cnt_o}, 32'h1);

    // 5: m0 aborts a wait-stated transfer, pending m1 is served next
    m_stb[0] = 1'b1; m_adr[0] = 32'h0000_2000;
    step();
    m_stb[1] = 1'b1;
    step();
    m_stb[0] = 1'b0;
    step();
    step();
    chk("t5_gnt", {30'h0, obs_gnt}, 32'h0);
    s_ack = 1'b1;
    step();
    chk("t5_m1_gnt", {30'h0, obs_gnt}, 32'h2);
    m_stb[1] = 1'b0; s_ack = 1'b0;
    step();

    // 6: reset during a stalled m0 transfer; m0 must win the next tie
    m_stb[0] = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_stb[1] = 1'b1;
    step();
    chk("t6_rst_gnt", {30'h0, obs_gnt}, 32'h0);
    s_ack = 1'b1;
    step();
    chk("t6_first", {30'h0, obs_gnt}, 32'h1);

    // Random traffic with random slave stalls, aborts and occasional resets
    clear_inputs();
    step();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      s_ack = ($urandom_range(0, 3) == 0);
      s_dat = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (m_stb[i]) begin
          if (done[i]) begin
            if ($urandom_range(0, 1) == 0) m_stb[i] = 1'b0;
            else new_req(i);
          end else if ($urandom_range(0, 24) == 0) begin
            m_stb[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "time limit");
  end

endmodule
